// File: rtl/eth_bd_access_ctrl.sv
// Initiator side of the Ethernet buffer-descriptor SRAM: arbitrates host and MAC
// engine accesses onto one single-port memory with registered controls and acks.
module eth_bd_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  h_req_i,
  input  logic [DATA_W/8-1:0]   h_we_i,
  input  logic [ADDR_W-1:0]     h_addr_i,
  input  logic [DATA_W-1:0]     h_wdata_i,
  output logic                  h_ack_o,
  output logic [DATA_W-1:0]     h_rdata_o,
  input  logic                  m_req_i,
  input  logic [DATA_W/8-1:0]   m_we_i,
  input  logic [ADDR_W-1:0]     m_addr_i,
  input  logic [DATA_W-1:0]     m_wdata_i,
  output logic                  m_ack_o,
  output logic [DATA_W-1:0]     m_rdata_o,
  output logic                  mem_ce_o,
  output logic [DATA_W/8-1:0]   mem_we_o,
  output logic                  mem_oe_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_di_o,
  input  logic [DATA_W-1:0]     mem_dato_i,
  output logic                  busy_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_e;
  typedef enum logic {GRANT_HOST, GRANT_MAC} grant_e;

  state_e              state_q;
  grant_e              grant_q;
  grant_e              last_grant_q;
  logic                is_read_q;
  logic                mem_ce_q;
  logic [BE_W-1:0]     mem_we_q;
  logic                mem_oe_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_di_q;
  logic                h_ack_q;
  logic                m_ack_q;
  logic [DATA_W-1:0]   h_rdata_q;
  logic [DATA_W-1:0]   m_rdata_q;

  grant_e              grant_d;
  logic [BE_W-1:0]     we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  // Under contention the port that did not win last time is served, so neither starves.
  always_comb begin
    grant_d = GRANT_HOST;
    if (h_req_i && m_req_i) begin
      grant_d = (last_grant_q == GRANT_HOST) ? GRANT_MAC : GRANT_HOST;
    end else if (m_req_i) begin
      grant_d = GRANT_MAC;
    end
    we_d    = (grant_d == GRANT_MAC) ? m_we_i    : h_we_i;
    addr_d  = (grant_d == GRANT_MAC) ? m_addr_i  : h_addr_i;
    wdata_d = (grant_d == GRANT_MAC) ? m_wdata_i : h_wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_HOST;
      last_grant_q <= GRANT_HOST;
      is_read_q    <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_oe_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_di_q     <= '0;
      h_ack_q      <= 1'b0;
      m_ack_q      <= 1'b0;
      h_rdata_q    <= '0;
      m_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (h_req_i || m_req_i) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            is_read_q    <= (we_d == '0);
            mem_ce_q     <= 1'b1;
            mem_we_q     <= we_d;
            mem_oe_q     <= (we_d == '0);
            mem_addr_q   <= addr_d;
            mem_di_q     <= wdata_d;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_ce_q <= 1'b0;
          mem_we_q <= '0;
          mem_oe_q <= 1'b0;
          if (is_read_q) begin
            state_q <= WAIT;
          end else begin
            h_ack_q <= (grant_q == GRANT_HOST);
            m_ack_q <= (grant_q == GRANT_MAC);
            state_q <= ACK;
          end
        end
        // Memory output for the read issued in ACCESS is valid during this cycle.
        WAIT: begin
          if (grant_q == GRANT_MAC) begin
            m_rdata_q <= mem_dato_i;
          end else begin
            h_rdata_q <= mem_dato_i;
          end
          h_ack_q <= (grant_q == GRANT_HOST);
          m_ack_q <= (grant_q == GRANT_MAC);
          state_q <= ACK;
        end
        ACK: begin
          h_ack_q <= 1'b0;
          m_ack_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ce_o   = mem_ce_q;
  assign mem_we_o   = mem_we_q;
  assign mem_oe_o   = mem_oe_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_di_o   = mem_di_q;
  assign h_ack_o    = h_ack_q;
  assign m_ack_o    = m_ack_q;
  assign h_rdata_o  = h_rdata_q;
  assign m_rdata_o  = m_rdata_q;
  assign busy_o     = (state_q != IDLE);

  a_ack_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni) !(h_ack_o && m_ack_o));
  a_oe_needs_ce:   assert property (@(posedge clk_i) disable iff (!rst_ni) mem_oe_o |-> mem_ce_o);
  a_ce_single:     assert property (@(posedge clk_i) disable iff (!rst_ni) mem_ce_o |=> !mem_ce_o);

endmodule

// File: tb/tb_eth_bd_access_ctrl.sv
// Scoreboard bench for eth_bd_access_ctrl: an SRAM model behind the DUT, a shadow memory
// reference and per-port expected-response queues checked by an ack monitor.
module tb_eth_bd_access_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        hReq, mReq;
  logic [3:0]  hWe, mWe;
  logic [7:0]  hAddr, mAddr;
  logic [31:0] hWdata, mWdata;
  logic        hAck, mAck;
  logic [31:0] hRdata, mRdata;
  logic        memCe, memOe;
  logic [3:0]  memWe;
  logic [7:0]  memAddr;
  logic [31:0] memDi;
  logic [31:0] memDato = 32'h0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram   [256];
  logic [31:0] shadow [256];
  logic [31:0] lastR  [2];
  logic [31:0] hExpQ[$];
  logic [31:0] mExpQ[$];
  int          ackOrder[$];
  bit          cePrev = 1'b0;

  always #5 clk = ~clk;

  eth_bd_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .h_req_i(hReq), .h_we_i(hWe), .h_addr_i(hAddr), .h_wdata_i(hWdata),
    .h_ack_o(hAck), .h_rdata_o(hRdata),
    .m_req_i(mReq), .m_we_i(mWe), .m_addr_i(mAddr), .m_wdata_i(mWdata),
    .m_ack_o(mAck), .m_rdata_o(mRdata),
    .mem_ce_o(memCe), .mem_we_o(memWe), .mem_oe_o(memOe),
    .mem_addr_o(memAddr), .mem_di_o(memDi), .mem_dato_i(memDato),
    .busy_o(busy)
  );

  // Memory macro: 256x32 single port, read data one cycle after a ce+oe cycle.
  initial begin
    for (int i = 0; i < 256; i++) sram[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
  end

  always @(posedge clk) begin
    if (memCe) begin
      for (int b = 0; b < 4; b++)
        if (memWe[b]) sram[memAddr][8*b +: 8] <= memDi[8*b +: 8];
      if (memOe) memDato <= sram[memAddr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctl"}, 32'({hAck, mAck, memCe, memOe, memWe, busy}), 32'h0);
    checkOutput({tag, " mem_addr"}, 32'(memAddr), 32'h0);
    checkOutput({tag, " mem_di"}, memDi, 32'h0);
    checkOutput({tag, " h_rdata"}, hRdata, 32'h0);
    checkOutput({tag, " m_rdata"}, mRdata, 32'h0);
  endtask

  // Issue one access on a port, push its expected response, wait for ack, then release.
  task automatic applyStimulus(input bit port, input logic [3:0] we, input logic [7:0] addr,
                               input logic [31:0] data, input int expLat);
    logic [31:0] exp;
    int n;
    bit got;
    if (we == 4'h0) begin
      exp = shadow[addr];
      lastR[int'(port)] = exp;
    end else begin
      exp = lastR[int'(port)];
      for (int b = 0; b < 4; b++)
        if (we[b]) shadow[addr][8*b +: 8] = data[8*b +: 8];
    end
    if (port) begin
      mExpQ.push_back(exp);
      mReq = 1'b1; mWe = we; mAddr = addr; mWdata = data;
    end else begin
      hExpQ.push_back(exp);
      hReq = 1'b1; hWe = we; hAddr = addr; hWdata = data;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (expLat != 0 && n == 2)
        checkOutput("ce at T1", 32'({memCe, memOe, memWe}), 32'({1'b1, (we == 4'h0), we}));
      got = port ? mAck : hAck;
    end
    if (!got) checkOutput("ack timeout", 32'(n), 32'(expLat));
    else if (expLat != 0) checkOutput("ack latency", 32'(n), 32'(expLat));
    @(posedge clk);
    #1;
    if (port) mReq = 1'b0;
    else      hReq = 1'b0;
  endtask

  // Monitor: every ack is matched against the head of that port's expected queue.
  always @(negedge clk) begin
    if (hAck || mAck) checkOutput("ack exclusive", 32'(hAck && mAck), 32'h0);
    if (hAck) begin
      ackOrder.push_back(0);
      checkOutput("h pending", 32'(hExpQ.size()), 32'd1);
      if (hExpQ.size() > 0) checkOutput("h_rdata", hRdata, hExpQ.pop_front());
    end
    if (mAck) begin
      ackOrder.push_back(1);
      checkOutput("m pending", 32'(mExpQ.size()), 32'd1);
      if (mExpQ.size() > 0) checkOutput("m_rdata", mRdata, mExpQ.pop_front());
    end
    if (memCe) begin
      checkOutput("mem_ce pulse", 32'(cePrev), 32'h0);
      checkOutput("mem_oe", 32'(memOe), 32'(memWe == 4'h0));
    end else if (cePrev) begin
      checkOutput("mem idle ctl", 32'({memOe, memWe}), 32'h0);
    end
    cePrev = memCe;
  end

  initial begin
    logic [31:0] wdat [8];
    int n;
    for (int i = 0; i < 256; i++) shadow[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
    lastR[0] = 32'h0;
    lastR[1] = 32'h0;
    rstN = 1'b0;
    hReq = 1'b0; hWe = 4'h0; hAddr = 8'h0; hWdata = 32'h0;
    mReq = 1'b0; mWe = 4'h0; mAddr = 8'h0; mWdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;

    $display("[TB] host write, read, byte merge");
    applyStimulus(1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 3);
    applyStimulus(1'b0, 4'h0, 8'h10, 32'h0, 4);
    checkOutput("host readback", hRdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 4'b0010, 8'h10, 32'h0000AB00, 3);
    applyStimulus(1'b0, 4'h0, 8'h10, 32'h0, 4);
    checkOutput("byte write readback", hRdata, 32'hDEADABEF);

    $display("[TB] contention");
    ackOrder.delete();
    fork
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'hF, 8'(8'hA0 + i), $urandom, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'hF, 8'(8'h20 + i), $urandom, 0);
    join
    checkOutput("arb count", 32'(ackOrder.size()), 32'd8);
    for (int i = 0; i < 8 && i < ackOrder.size(); i++)
      checkOutput("arb order", 32'(ackOrder[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    $display("[TB] reset during read wait");
    mReq = 1'b1; mWe = 4'h0; mAddr = 8'hFF; mWdata = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!memCe && n < 20);
    if (!memCe) checkOutput("wait ce", 32'h0, 32'h1);
    @(posedge clk);
    #1 rstN = 1'b0;
    mReq = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    lastR[0] = 32'h0;
    lastR[1] = 32'h0;
    @(negedge clk);
    checkAllZero("mid reset");
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 4'h0, 8'h10, 32'h0, 4);

    $display("[TB] back-to-back MAC writes");
    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom;
      applyStimulus(1'b1, 4'hF, 8'(i), wdat[i], 3);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 4'h0, 8'(i), 32'h0, 4);
      checkOutput("b2b readback", mRdata, wdat[i]);
    end

    $display("[TB] random traffic");
    fork
      for (int k = 0; k < 30; k++) begin
        int gap = $urandom_range(0, 3);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        applyStimulus(1'b0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                      8'($urandom_range(0, 127)), $urandom, 0);
      end
      for (int k = 0; k < 30; k++) begin
        int gap = $urandom_range(0, 3);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        applyStimulus(1'b1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                      8'($urandom_range(128, 255)), $urandom, 0);
      end
    join

    repeat (5) @(posedge clk);
    checkOutput("h queue drained", 32'(hExpQ.size()), 32'h0);
    checkOutput("m queue drained", 32'(mExpQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
